// File: rtl/bullet.sv
// Projectile pool for one tank: spawns on a fire edge, steps live bullets each cycle,
// retires them at the screen edge or on contact with the opponent, and pulses hit.
module bullet #(
  parameter int MAX_BULLETS = 8,
  parameter int BULLET_SIZE = 4,
  parameter int TANK_SIZE   = 32,
  parameter int SPEED       = 2,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fire,
  input  logic [1:0]  bullet_direction,
  input  logic [9:0]  init_x,
  input  logic [9:0]  init_y,
  input  logic [9:0]  oppo_x,
  input  logic [9:0]  oppo_y,
  output logic        hit,
  output logic [2:0]  bullet_addr  [MAX_BULLETS],
  output logic [31:0] bullet_state [MAX_BULLETS]
);

  localparam logic [1:0] DIR_UP = 2'b00;
  localparam logic [1:0] DIR_DN = 2'b01;
  localparam logic [1:0] DIR_LT = 2'b10;
  localparam logic [1:0] DIR_RT = 2'b11;

  localparam logic [10:0] BS   = 11'(BULLET_SIZE);
  localparam logic [10:0] TS   = 11'(TANK_SIZE);
  localparam logic [10:0] SP   = 11'(SPEED);
  localparam logic [10:0] XMAX = 11'(SCREEN_W - BULLET_SIZE);
  localparam logic [10:0] YMAX = 11'(SCREEN_H - BULLET_SIZE);
  localparam logic [9:0]  STEP = 10'(SPEED);

  logic [MAX_BULLETS-1:0] act_q, act_d;
  logic [9:0]             x_q   [MAX_BULLETS];
  logic [9:0]             x_d   [MAX_BULLETS];
  logic [9:0]             y_q   [MAX_BULLETS];
  logic [9:0]             y_d   [MAX_BULLETS];
  logic [1:0]             dir_q [MAX_BULLETS];
  logic [1:0]             dir_d [MAX_BULLETS];
  logic                   hit_q, hit_d;
  logic                   fire_q, fire_d;
  logic                   taken;

  logic [MAX_BULLETS-1:0] coll;
  logic [MAX_BULLETS-1:0] leave;

  logic [10:0] ox, oy;
  assign ox = {1'b0, oppo_x};
  assign oy = {1'b0, oppo_y};

  for (genvar g = 0; g < MAX_BULLETS; g++) begin : g_slot
    logic [10:0] bx, by;
    assign bx = {1'b0, x_q[g]};
    assign by = {1'b0, y_q[g]};
    assign coll[g] = act_q[g]
                   && (bx + BS > ox) && (bx < ox + TS)
                   && (by + BS > oy) && (by < oy + TS);
    assign leave[g] = (dir_q[g] == DIR_UP) ? (by < SP) :
                      (dir_q[g] == DIR_DN) ? (by + SP > YMAX) :
                      (dir_q[g] == DIR_LT) ? (bx < SP) :
                                             (bx + SP > XMAX);
    assign bullet_addr[g]  = 3'(g);
    assign bullet_state[g] = {act_q[g], dir_q[g], 9'd0,
                              x_q[g], y_q[g]};
  end

  always_comb begin
    act_d  = act_q;
    x_d    = x_q;
    y_d    = y_q;
    dir_d  = dir_q;
    hit_d  = 1'b0;
    fire_d = fire;
    taken  = 1'b0;
    // collision outranks the edge check, which outranks movement
    for (int i = 0; i < MAX_BULLETS; i++) begin
      if (act_q[i]) begin
        if (coll[i]) begin
          act_d[i] = 1'b0;
          hit_d    = 1'b1;
        end else if (leave[i]) begin
          act_d[i] = 1'b0;
        end else begin
          unique case (dir_q[i])
            DIR_UP: y_d[i] = y_q[i] - STEP;
            DIR_DN: y_d[i] = y_q[i] + STEP;
            DIR_LT: x_d[i] = x_q[i] - STEP;
            DIR_RT: x_d[i] = x_q[i] + STEP;
          endcase
        end
      end
    end
    // only slots free before this edge are eligible
    if (fire && !fire_q) begin
      for (int i = 0; i < MAX_BULLETS; i++) begin
        if (!act_q[i] && !taken) begin
          taken    = 1'b1;
          act_d[i] = 1'b1;
          x_d[i]   = init_x;
          y_d[i]   = init_y;
          dir_d[i] = bullet_direction;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_q  <= '0;
      x_q    <= '{default: '0};
      y_q    <= '{default: '0};
      dir_q  <= '{default: '0};
      hit_q  <= 1'b0;
      fire_q <= 1'b0;
    end else begin
      act_q  <= act_d;
      x_q    <= x_d;
      y_q    <= y_d;
      dir_q  <= dir_d;
      hit_q  <= hit_d;
      fire_q <= fire_d;
    end
  end

  assign hit = hit_q;

endmodule

// File: tb/tb_bullet.sv
// Directed bench for the bullet pool: spawn, motion, hit, edge exit,
// pool exhaustion and asynchronous reset.
module tb_bullet;

  logic        clk;
  logic        reset;
  logic        fire;
  logic [1:0]  bullet_direction;
  logic [9:0]  init_x, init_y, oppo_x, oppo_y;
  logic        hit;
  logic [2:0]  bullet_addr  [8];
  logic [31:0] bullet_state [8];

  int errs;
  int checks;

  bullet dut (
    .clk              (clk),
    .reset            (reset),
    .fire             (fire),
    .bullet_direction (bullet_direction),
    .init_x           (init_x),
    .init_y           (init_y),
    .oppo_x           (oppo_x),
    .oppo_y           (oppo_y),
    .hit              (hit),
    .bullet_addr      (bullet_addr),
    .bullet_state     (bullet_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic a, input logic [1:0] d,
                                     input logic [9:0] x, input logic [9:0] y);
    return {a, d, 9'd0, x, y};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic shot(input logic [1:0] d, input logic [9:0] x,
                      input logic [9:0] y);
    fire = 1'b1;
    bullet_direction = d;
    init_x = x;
    init_y = y;
    step();
    fire = 1'b0;
  endtask

  initial begin
    errs = 0;
    checks = 0;
    reset = 1'b1;
    fire = 1'b0;
    bullet_direction = 2'b00;
    init_x = '0;
    init_y = '0;
    oppo_x = 10'd32;
    oppo_y = 10'd64;
    @(negedge clk);
    @(negedge clk);

    chk("rst_hit", 32'(hit), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rst_state%0d", i), bullet_state[i], 32'd0);
      chk($sformatf("addr%0d", i), 32'(bullet_addr[i]), 32'(i));
    end
    reset = 1'b0;
    @(negedge clk);

    // single shot upward into the opponent
    shot(2'b00, 10'd32, 10'd128);
    chk("spawn_up", bullet_state[0], mk(1'b1, 2'b00, 10'd32, 10'd128));
    for (int k = 1; k <= 17; k++) begin
      step();
      chk($sformatf("up_k%0d", k), bullet_state[0],
          mk(1'b1, 2'b00, 10'd32, 10'(128 - 2 * k)));
      chk($sformatf("nohit_k%0d", k), 32'(hit), 32'd0);
    end
    step();
    chk("hit_k18", 32'(hit), 32'd1);
    chk("dead_k18", 32'(bullet_state[0][31]), 32'd0);
    step();
    chk("hit_k19", 32'(hit), 32'd0);

    // fire held high spawns once
    oppo_x = 10'd600;
    oppo_y = 10'd0;
    fire = 1'b1;
    bullet_direction = 2'b00;
    init_x = 10'd32;
    init_y = 10'd128;
    for (int k = 0; k < 5; k++) step();
    chk("hold_s0", bullet_state[0], mk(1'b1, 2'b00, 10'd32, 10'd120));
    chk("hold_s1", 32'(bullet_state[1][31]), 32'd0);
    fire = 1'b0;
    step();
    shot(2'b11, 10'd32, 10'd128);
    chk("spawn_rt", bullet_state[1], mk(1'b1, 2'b11, 10'd32, 10'd128));
    chk("s0_116", bullet_state[0], mk(1'b1, 2'b00, 10'd32, 10'd116));
    step();
    chk("rt_34", bullet_state[1], mk(1'b1, 2'b11, 10'd34, 10'd128));
    step();
    chk("rt_36", bullet_state[1], mk(1'b1, 2'b11, 10'd36, 10'd128));
    chk("s0_112", bullet_state[0], mk(1'b1, 2'b00, 10'd32, 10'd112));
    shot(2'b01, 10'd100, 10'd100);
    chk("spawn_dn", bullet_state[2], mk(1'b1, 2'b01, 10'd100, 10'd100));

    // asynchronous reset with three live bullets
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 8; i++)
      chk($sformatf("async_rst%0d", i), bullet_state[i], 32'd0);
    chk("async_hit", 32'(hit), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // top edge exit
    shot(2'b00, 10'd200, 10'd3);
    chk("top_y3", bullet_state[0], mk(1'b1, 2'b00, 10'd200, 10'd3));
    step();
    chk("top_y1", bullet_state[0], mk(1'b1, 2'b00, 10'd200, 10'd1));
    step();
    chk("top_gone", 32'(bullet_state[0][31]), 32'd0);
    chk("top_nohit", 32'(hit), 32'd0);

    // right edge exit
    shot(2'b11, 10'd634, 10'd200);
    chk("rt_634", bullet_state[0], mk(1'b1, 2'b11, 10'd634, 10'd200));
    step();
    chk("rt_636", bullet_state[0], mk(1'b1, 2'b11, 10'd636, 10'd200));
    step();
    chk("rt_gone", 32'(bullet_state[0][31]), 32'd0);
    chk("rt_nohit", 32'(hit), 32'd0);

    // fill the pool: slot j at x=100+40j moving down from y=0
    for (int j = 0; j < 8; j++) begin
      shot(2'b01, 10'(100 + 40 * j), 10'd0);
      step();
    end
    shot(2'b10, 10'd300, 10'd300);
    chk("full_s0", bullet_state[0], mk(1'b1, 2'b01, 10'd100, 10'd32));
    chk("full_s7", bullet_state[7], mk(1'b1, 2'b01, 10'd380, 10'd4));
    chk("full_s3", bullet_state[3], mk(1'b1, 2'b01, 10'd220, 10'd20));
    step();
    oppo_x = 10'd220;
    oppo_y = 10'd0;
    step();
    chk("pool_hit", 32'(hit), 32'd1);
    chk("s3_dead", 32'(bullet_state[3][31]), 32'd0);
    chk("s4_live", bullet_state[4], mk(1'b1, 2'b01, 10'd260, 10'd20));
    oppo_x = 10'd600;
    shot(2'b10, 10'd300, 10'd300);
    chk("reuse_s3", bullet_state[3], mk(1'b1, 2'b10, 10'd300, 10'd300));
    chk("reuse_nohit", 32'(hit), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
